// File: rtl/muldiv_unit.sv
// Multiply/divide unit owning the HI/LO pair: fixed-latency multiply path with
// accumulate/subtract forms, and an iterative restoring divider (one bit per cycle).
module muldiv_unit #(
  parameter int unsigned WIDTH       = 32,
  parameter int unsigned MUL_LATENCY = 5
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [3:0]       op,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  input  logic             cancel,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] HI,
  output logic [WIDTH-1:0] LO
);

  localparam int unsigned MAX_CNT = (WIDTH > MUL_LATENCY) ? WIDTH : MUL_LATENCY;
  localparam int unsigned CNT_W   = $clog2(MAX_CNT + 1);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_MUL  = 2'd1;
  localparam logic [1:0] S_DIV  = 2'd2;

  logic [1:0]         state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [3:0]         op_q, op_d;
  logic [WIDTH-1:0]   a_q, a_d, b_q, b_d;
  logic [WIDTH-1:0]   quo_q, quo_d, rem_q, rem_d;
  logic [WIDTH-1:0]   hi_q, hi_d, lo_q, lo_d;
  logic               busy_q, busy_d, done_q, done_d;

  // Multiply datapath: extend to 2*WIDTH so one unsigned multiply serves both signednesses
  logic [2*WIDTH-1:0] a_ext, b_ext, prod, acc;
  assign a_ext = op_q[0] ? {{WIDTH{1'b0}}, a_q} : {{WIDTH{a_q[WIDTH-1]}}, a_q};
  assign b_ext = op_q[0] ? {{WIDTH{1'b0}}, b_q} : {{WIDTH{b_q[WIDTH-1]}}, b_q};
  assign prod  = a_ext * b_ext;
  assign acc   = {hi_q, lo_q};

  // Divide datapath: magnitude restoring step and signed fixup controls
  logic [WIDTH-1:0] dvs;
  logic [WIDTH:0]   rem_shift;
  logic             rem_ge, q_neg, r_neg;
  assign dvs       = (!op_q[0] && b_q[WIDTH-1]) ? -b_q : b_q;
  assign rem_shift = {rem_q, quo_q[WIDTH-1]};
  assign rem_ge    = rem_shift >= {1'b0, dvs};
  assign q_neg     = !op_q[0] && (a_q[WIDTH-1] ^ b_q[WIDTH-1]);
  assign r_neg     = !op_q[0] && a_q[WIDTH-1];

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    op_d    = op_q;
    a_d     = a_q;
    b_d     = b_q;
    quo_d   = quo_q;
    rem_d   = rem_q;
    hi_d    = hi_q;
    lo_d    = lo_q;
    busy_d  = busy_q;
    done_d  = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (start && !cancel) begin
          case (op)
            4'd0, 4'd1, 4'd4, 4'd5, 4'd6, 4'd7: begin
              state_d = S_MUL;
              busy_d  = 1'b1;
              op_d    = op;
              a_d     = A;
              b_d     = B;
              cnt_d   = '0;
            end
            4'd2, 4'd3: begin
              state_d = S_DIV;
              busy_d  = 1'b1;
              op_d    = op;
              a_d     = A;
              b_d     = B;
              cnt_d   = '0;
              rem_d   = '0;
              quo_d   = (!op[0] && A[WIDTH-1]) ? -A : A;
            end
            4'd8:    hi_d = A;
            4'd9:    lo_d = A;
            default: ;
          endcase
        end
      end
      S_MUL: begin
        if (cancel) begin
          state_d = S_IDLE;
          busy_d  = 1'b0;
        end else if (cnt_q == CNT_W'(MUL_LATENCY - 1)) begin
          case (op_q)
            4'd4, 4'd5: {hi_d, lo_d} = acc + prod;
            4'd6, 4'd7: {hi_d, lo_d} = acc - prod;
            default:    {hi_d, lo_d} = prod;
          endcase
          state_d = S_IDLE;
          busy_d  = 1'b0;
          done_d  = 1'b1;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      S_DIV: begin
        if (cancel) begin
          state_d = S_IDLE;
          busy_d  = 1'b0;
        end else if (cnt_q == CNT_W'(WIDTH)) begin
          // Divide by zero bypasses the fixup and reports the dividend unchanged
          if (b_q == '0) begin
            lo_d = '1;
            hi_d = a_q;
          end else begin
            lo_d = q_neg ? -quo_q : quo_q;
            hi_d = r_neg ? -rem_q : rem_q;
          end
          state_d = S_IDLE;
          busy_d  = 1'b0;
          done_d  = 1'b1;
        end else begin
          rem_d = rem_ge ? WIDTH'(rem_shift - {1'b0, dvs}) : rem_shift[WIDTH-1:0];
          quo_d = {quo_q[WIDTH-2:0], rem_ge};
          cnt_d = cnt_q + 1'b1;
        end
      end
      default: begin
        state_d = S_IDLE;
        busy_d  = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      op_q    <= '0;
      a_q     <= '0;
      b_q     <= '0;
      quo_q   <= '0;
      rem_q   <= '0;
      hi_q    <= '0;
      lo_q    <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      op_q    <= op_d;
      a_q     <= a_d;
      b_q     <= b_d;
      quo_q   <= quo_d;
      rem_q   <= rem_d;
      hi_q    <= hi_d;
      lo_q    <= lo_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
    end
  end

  assign busy = busy_q;
  assign done = done_q;
  assign HI   = hi_q;
  assign LO   = lo_q;

endmodule

// File: tb/tb_muldiv_unit.sv
// Bench for muldiv_unit: directed cases at 32/5 and a randomized run at 8/1
// against an arithmetic reference model.
module tb_muldiv_unit;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic reset;

  logic        start_b, cancel_b, busy_b, done_b;
  logic [3:0]  op_b;
  logic [31:0] a_b, b_b, hi_b, lo_b;

  logic        start_s, cancel_s, busy_s, done_s;
  logic [3:0]  op_s;
  logic [7:0]  a_s, b_s, hi_s, lo_s;

  muldiv_unit #(.WIDTH(32), .MUL_LATENCY(5)) u_big (
    .clk(clk), .reset(reset), .start(start_b), .op(op_b), .A(a_b), .B(b_b),
    .cancel(cancel_b), .busy(busy_b), .done(done_b), .HI(hi_b), .LO(lo_b)
  );

  muldiv_unit #(.WIDTH(8), .MUL_LATENCY(1)) u_small (
    .clk(clk), .reset(reset), .start(start_s), .op(op_s), .A(a_s), .B(b_s),
    .cancel(cancel_s), .busy(busy_s), .done(done_s), .HI(hi_s), .LO(lo_s)
  );

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Reference model: plain integer arithmetic on a w-bit machine
  function automatic longint sext(input longint unsigned x, input int w);
    longint v;
    v = $signed(x);
    if (x[w-1]) v = v - (longint'(1) << w);
    return v;
  endfunction

  function automatic void model(input int w, input logic [3:0] o,
                                input longint unsigned a, input longint unsigned b,
                                inout longint unsigned hi, inout longint unsigned lo);
    longint unsigned mw, m2, acc, p;
    longint sa, sb;
    mw  = (64'd1 << w) - 64'd1;
    m2  = (2 * w >= 64) ? {64{1'b1}} : ((64'd1 << (2 * w)) - 64'd1);
    acc = (hi << w) | lo;
    sa  = sext(a, w);
    sb  = sext(b, w);
    p   = o[0] ? a * b : $unsigned(sa * sb);
    case (o)
      4'd0, 4'd1, 4'd4, 4'd5, 4'd6, 4'd7: begin
        if (o == 4'd0 || o == 4'd1) acc = p;
        else if (o == 4'd4 || o == 4'd5) acc = acc + p;
        else acc = acc - p;
        acc = acc & m2;
        hi  = (acc >> w) & mw;
        lo  = acc & mw;
      end
      4'd2, 4'd3: begin
        if (b == 0) begin
          lo = mw;
          hi = a;
        end else if (o[0]) begin
          lo = a / b;
          hi = a % b;
        end else begin
          lo = $unsigned(sa / sb) & mw;
          hi = $unsigned(sa % sb) & mw;
        end
      end
      4'd8:    hi = a;
      4'd9:    lo = a;
      default: ;
    endcase
  endfunction

  task automatic issue_b(input logic [3:0] o, input logic [31:0] a, input logic [31:0] b);
    start_b = 1'b1; op_b = o; a_b = a; b_b = b;
    tick();
    start_b = 1'b0;
  endtask

  task automatic wait_done_b(input string tag, input int k0, input int lat);
    int k;
    k = k0;
    check({tag, " busy"}, 64'(busy_b), 64'd1);
    while (!done_b && k < 200) begin
      tick();
      k++;
    end
    check({tag, " latency"}, 64'(k), 64'(lat));
    check({tag, " busy_off"}, 64'(busy_b), 64'd0);
  endtask

  task automatic run_b(input string tag, input logic [3:0] o, input logic [31:0] a,
                       input logic [31:0] b, input int lat,
                       input logic [31:0] ehi, input logic [31:0] elo);
    issue_b(o, a, b);
    wait_done_b(tag, 0, lat);
    check({tag, " HI"}, 64'(hi_b), 64'(ehi));
    check({tag, " LO"}, 64'(lo_b), 64'(elo));
    tick();
    check({tag, " done_1cyc"}, 64'(done_b), 64'd0);
  endtask

  task automatic issue_s(input logic [3:0] o, input logic [7:0] a, input logic [7:0] b);
    start_s = 1'b1; op_s = o; a_s = a; b_s = b;
    tick();
    start_s = 1'b0;
  endtask

  function automatic logic [7:0] pick8();
    case ($urandom_range(0, 7))
      0:       return 8'h00;
      1:       return 8'h80;
      2:       return 8'hFF;
      3:       return 8'h01;
      default: return 8'($urandom);
    endcase
  endfunction

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    int seen, k, kc, lat;
    longint unsigned hm, lm;
    logic [3:0] o;
    logic [7:0] ra, rb;
    string tag;

    reset = 1'b1;
    start_b = 0; cancel_b = 0; op_b = 0; a_b = 0; b_b = 0;
    start_s = 0; cancel_s = 0; op_s = 0; a_s = 0; b_s = 0;
    repeat (3) tick();
    reset = 1'b0;
    tick();
    check("reset HI", 64'(hi_b), 64'd0);
    check("reset LO", 64'(lo_b), 64'd0);
    check("reset busy", 64'(busy_b), 64'd0);
    check("reset done", 64'(done_b), 64'd0);
    check("reset small HI/LO", 64'({hi_s, lo_s}), 64'd0);

    run_b("mult", 4'd0, 32'hFFFFFFFD, 32'd5, 5, 32'hFFFFFFFF, 32'hFFFFFFF1);
    run_b("multu", 4'd1, 32'hFFFFFFFD, 32'd5, 5, 32'h00000004, 32'hFFFFFFF1);
    run_b("divu", 4'd3, 32'd100, 32'd7, 33, 32'd2, 32'd14);
    run_b("div neg", 4'd2, 32'hFFFFFFF9, 32'd2, 33, 32'hFFFFFFFF, 32'hFFFFFFFD);
    run_b("div ovf", 4'd2, 32'h80000000, 32'hFFFFFFFF, 33, 32'd0, 32'h80000000);

    issue_b(4'd8, 32'h10, 32'd0);
    check("mthi HI", 64'(hi_b), 64'h10);
    check("mthi busy", 64'(busy_b), 64'd0);
    check("mthi done", 64'(done_b), 64'd0);
    issue_b(4'd9, 32'h20, 32'd0);
    check("mtlo LO", 64'(lo_b), 64'h20);
    run_b("msub", 4'd6, 32'd3, 32'd4, 5, 32'h10, 32'h14);
    run_b("maddu", 4'd5, 32'hFFFFFFFF, 32'd2, 5, 32'h12, 32'h12);
    run_b("divu by0", 4'd3, 32'h1234, 32'd0, 33, 32'h1234, 32'hFFFFFFFF);

    // Cancel an in-flight divide in its tenth cycle
    issue_b(4'd2, 32'd50, 32'd3);
    repeat (9) tick();
    cancel_b = 1'b1;
    tick();
    cancel_b = 1'b0;
    check("cancel busy", 64'(busy_b), 64'd0);
    seen = 0;
    repeat (40) begin
      tick();
      if (done_b) seen++;
    end
    check("cancel no done", 64'(seen), 64'd0);
    check("cancel HI", 64'(hi_b), 64'h1234);
    check("cancel LO", 64'(lo_b), 64'hFFFFFFFF);

    // Start held while busy must not be taken
    issue_b(4'd1, 32'd2, 32'd3);
    start_b = 1'b1; op_b = 4'd8; a_b = 32'hDEAD;
    tick();
    tick();
    start_b = 1'b0;
    wait_done_b("busy start", 2, 5);
    check("busy start HI", 64'(hi_b), 64'd0);
    check("busy start LO", 64'(lo_b), 64'd6);

    // Cancel while idle drops a simultaneous start
    start_b = 1'b1; cancel_b = 1'b1; op_b = 4'd0; a_b = 32'd3; b_b = 32'd3;
    tick();
    check("idle cancel mult busy", 64'(busy_b), 64'd0);
    op_b = 4'd9; a_b = 32'h55;
    tick();
    start_b = 1'b0; cancel_b = 1'b0;
    check("idle cancel mtlo LO", 64'(lo_b), 64'd6);

    // Reset in the middle of a multiply
    issue_b(4'd0, 32'd7, 32'd9);
    tick();
    tick();
    reset = 1'b1;
    tick();
    reset = 1'b0;
    check("midreset HI", 64'(hi_b), 64'd0);
    check("midreset LO", 64'(lo_b), 64'd0);
    check("midreset busy", 64'(busy_b), 64'd0);
    seen = 0;
    repeat (8) begin
      tick();
      if (done_b) seen++;
    end
    check("midreset no done", 64'(seen), 64'd0);

    // Back-to-back: next start issued in the done cycle
    issue_b(4'd1, 32'd3, 32'd4);
    wait_done_b("b2b first", 0, 5);
    issue_b(4'd5, 32'd1, 32'd1);
    check("b2b done_clr", 64'(done_b), 64'd0);
    wait_done_b("b2b second", 0, 5);
    check("b2b HI", 64'(hi_b), 64'd0);
    check("b2b LO", 64'(lo_b), 64'd13);
    tick();

    // Randomized run on the 8-bit, single-cycle-multiply instance
    hm = 0;
    lm = 0;
    for (int i = 0; i < 400; i++) begin
      o   = 4'($urandom_range(0, 15));
      ra  = pick8();
      rb  = pick8();
      tag = $sformatf("rnd%0d op%0d a%0h b%0h", i, o, ra, rb);
      issue_s(o, ra, rb);
      check({tag, " done_clr"}, 64'(done_s), 64'd0);
      if (o <= 4'd7) begin
        lat = (o == 4'd2 || o == 4'd3) ? 9 : 1;
        check({tag, " busy"}, 64'(busy_s), 64'd1);
        if (lat > 1 && $urandom_range(0, 5) == 0) begin
          kc = $urandom_range(1, lat - 1);
          repeat (kc - 1) tick();
          cancel_s = 1'b1;
          tick();
          cancel_s = 1'b0;
          check({tag, " cancel busy"}, 64'(busy_s), 64'd0);
          check({tag, " cancel done"}, 64'(done_s), 64'd0);
        end else begin
          k = 0;
          while (!done_s && k < 100) begin
            tick();
            k++;
          end
          check({tag, " latency"}, 64'(k), 64'(lat));
          check({tag, " busy_off"}, 64'(busy_s), 64'd0);
          model(8, o, 64'(ra), 64'(rb), hm, lm);
        end
      end else begin
        check({tag, " busy"}, 64'(busy_s), 64'd0);
        model(8, o, 64'(ra), 64'(rb), hm, lm);
      end
      check({tag, " HI"}, 64'(hi_s), hm);
      check({tag, " LO"}, 64'(lo_s), lm);
      if ($urandom_range(0, 3) == 0) repeat ($urandom_range(1, 3)) tick();
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/muldiv_unit.md
# muldiv_unit

Parametrised multiply/divide unit for the execute stage, owning the architectural HI/LO pair. Multiplies use a fixed-latency pipelined path. Divides use an iterative restoring divider at one quotient bit per cycle. Adds multiply-accumulate/subtract in signed and unsigned forms, a cancel input for exception flush, a completion pulse, and defined divide-by-zero results.

## Interface
- WIDTH, 32, operand width and width of HI and LO; must be ≥ 4.
- MUL_LATENCY, 5, cycles from accepted multiply-class start to result; must be ≥ 1.

Ports:
- clk  in  1  clock; all state updates on rising edge.
- reset  in  1  synchronous, active-high reset.
- start  in  1  request; sampled only when busy=0.
- op  in  4  operation code, listed below.
- A  in  WIDTH  operand A (dividend / multiplicand; value for MTHI/MTLO).
- B  in  WIDTH  operand B (divisor / multiplier).
- cancel  in  1  abort the in-flight operation.
- busy  out  1  operation in flight.
- done  out  1  one-cycle pulse when HI/LO are written by a multiply/divide-class op.
- HI  out  WIDTH  high word / remainder.
- LO  out  WIDTH  low word / quotient.

## Operation
- op codes:
  - 0 MULT, 1 MULTU: {HI,LO} = A*B (signed / unsigned, 2·WIDTH bits).
  - 2 DIV, 3 DIVU: LO = quotient, HI = remainder.
  - 4 MADD, 5 MADDU: {HI,LO} += A*B.
  - 6 MSUB, 7 MSUBU: {HI,LO} −= A*B.
  - 8 MTHI: HI = A.
  - 9 MTLO: LO = A.
  - 10–15: no effect.
- Reset values: HI=0, LO=0, busy=0, done=0. Internal counter and operand registers are cleared.
- States are IDLE, MUL, DIV.
  - IDLE, start with op 0–1 or 4–7: latch A, B, op; go to MUL; busy=1.
  - IDLE, start with op 2–3: latch operands; go to DIV; busy=1.
  - IDLE, start with op 8/9: write HI/LO on that edge; stay IDLE; busy stays 0; no done.
  - start while busy=1 is ignored. The requester holds start until busy=0.
- Accumulate ops use the HI/LO values present at the completion edge, then add/subtract the full 2·WIDTH-bit product, modulo 2^(2·WIDTH).
- Signed product uses the two's-complement interpretation of both operands. Unsigned product uses zero extension.
- Division datapath:
  - Operate on magnitudes with an unsigned restoring algorithm: WIDTH iterations, one per cycle, using a (WIDTH+1)-bit partial remainder.
  - Signed fixup: quotient negated iff operand signs differ; remainder takes the sign of the dividend (truncation toward zero).
  - Most-negative / −1: LO = most-negative value, HI = 0, with no trap.
- Divide by zero (B=0), signed or unsigned: LO = all ones, HI = A. The op still runs the full latency.
- cancel:
  - When busy=1, cancel returns the unit to IDLE on that edge. busy=0 next cycle; HI/LO unchanged; no done.
  - When busy=0, cancel has no effect and takes priority over start in the same cycle (start is dropped).
- reset has priority over everything, including mid-operation: it returns to IDLE with HI/LO zeroed.

## Timing
- Let E0 be the edge where start is accepted.
- MUL: busy=1 after E0. At edge E_MUL_LATENCY, HI/LO are written, busy→0 and done→1, all visible the following cycle. done lasts exactly one cycle.
- DIV:
  - Iteration edges are E1..E_WIDTH.
  - The fixup/write edge is E_(WIDTH+1): HI/LO written, busy→0, done→1.
  - busy is therefore high for WIDTH+1 cycles (33 at default).
- Back-to-back: a new start may be accepted in the first cycle busy=0, i.e. the cycle in which done=1.
- MTHI/MTLO: result visible the cycle after E0; zero-cycle busy.
- HI/LO never change except on a completion edge, an MTHI/MTLO edge, or reset.

## Test plan
- MULT A=0xFFFFFFFD (−3), B=5 → after 5 cycles HI=0xFFFFFFFF, LO=0xFFFFFFF1; done pulses once. MULTU with the same operands → HI=0x00000004, LO=0xFFFFFFF1.
- DIVU A=100, B=7 → busy for 33 cycles, then LO=14, HI=2. DIV A=−7, B=2 → LO=0xFFFFFFFD, HI=0xFFFFFFFF. DIV A=0x80000000, B=0xFFFFFFFF → LO=0x80000000, HI=0.
- MTHI 0x10, MTLO 0x20, then MSUB A=3, B=4 → {HI,LO}=0x00000010_00000014. Then MADDU A=0xFFFFFFFF, B=2 → HI=0x12, LO=0x12.
- DIVU A=0x1234, B=0 → LO=0xFFFFFFFF, HI=0x1234 after 33 cycles.
- Start DIV, pulse cancel at cycle 10 → busy=0 next cycle, HI/LO unchanged, no done. Also: start asserted during busy is ignored; reset asserted mid-MULT → HI=LO=0, busy=0.
- Parameter sweep WIDTH=8, MUL_LATENCY=1 against a randomized reference model over all ops, including completion-cycle back-to-back starts.
